fifo_v4_sram: RTL

Parametrised synchronous FIFO built on an inferred single-clock SRAM array with a registered read port and a one-entry prefetch output register.
- Presents first-word-fall-through data on data_o while empty_o is low.
- Supports arbitrary DATA_WIDTH and DEPTH, programmable almost-full and almost-empty levels, and sticky overflow/underflow flags.
- Drop-in for CPU-side queues such as store buffer and instruction queue, in place of vendor FIFO macros.

---
 rtl/fifo_v4_sram_if.sv | 42 ++++
 rtl/fifo_v4_sram.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fifo_v4_sram_if.sv
// fifo_v4_sram_if: handshake and status bundle for fifo_v4_sram.
//   master modport : the producer/consumer side (drives push/pop/data_i/flush)
//   slave modport  : the FIFO itself (drives data_o and all status flags)
//   flush_i        : synchronous clear of all contents
//   testmode_i     : carried for interface compatibility, no function
//   data_i/push_i  : push payload and request
//   pop_i          : pop request
//   data_o         : head entry, valid while empty_o is low
//   full_o, empty_o, usage_o, almost_full_o, almost_empty_o : occupancy status
//   overflow_o, underflow_o : sticky error flags
interface fifo_v4_sram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  flush_i;
  logic                  testmode_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  push_i;
  logic                  pop_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  full_o;
  logic                  empty_o;
  logic [CNT_W-1:0]      usage_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output flush_i, testmode_i, data_i, push_i, pop_i,
    input  data_o, full_o, empty_o, usage_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, testmode_i, data_i, push_i, pop_i,
    output data_o, full_o, empty_o, usage_o, almost_full_o,
           almost_empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/fifo_v4_sram.sv
// fifo_v4_sram: synchronous FIFO on an inferred single-clock RAM whose
// registered read port doubles as a one-entry prefetch/output register, so
// the head entry falls through to data_o while empty_o is low.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (RAM contents are not reset)
//   bus    : fifo_v4_sram_if.slave, push/pop handshake plus status flags
// usage_o counts entries in the RAM plus the output register. A push into an
// empty FIFO reaches data_o two edges later (write, then prefetch read), so
// usage_o=1 with empty_o=1 is a normal transient.
module fifo_v4_sram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned ADDR_DEPTH = $clog2(DEPTH),
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fifo_v4_sram_if.slave bus
);

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  dtype                  mem_r [DEPTH];
  dtype                  data_r;
  logic [ADDR_DEPTH-1:0] wr_ptr_r;
  logic [ADDR_DEPTH-1:0] rd_ptr_r;
  logic [CNT_W-1:0]      ram_count_r;
  logic [CNT_W-1:0]      usage_r;
  logic [CNT_W-1:0]      ram_count_nxt_s;
  logic [CNT_W-1:0]      usage_nxt_s;
  logic                  out_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  full_s;
  logic                  push_acc_s;
  logic                  pop_acc_s;
  logic                  rd_en_s;
  logic                  wr_en_s;
  logic                  unused_testmode_s;

  assign unused_testmode_s = bus.testmode_i;

  // Acceptance is judged on the registered state seen in this cycle.
  assign full_s     = (usage_r == FULL_LVL);
  assign push_acc_s = bus.push_i & ~full_s;
  assign pop_acc_s  = bus.pop_i & out_valid_r;
  // Refill the output register whenever it is, or is about to become, empty.
  assign rd_en_s    = (ram_count_r != {CNT_W{1'b0}}) & (~out_valid_r | pop_acc_s);
  assign wr_en_s    = push_acc_s & ~bus.flush_i;

  // RAM occupancy: pushes fill it, prefetch reads drain it into the output register.
  always_comb begin
    ram_count_nxt_s = ram_count_r;
    case ({push_acc_s, rd_en_s})
      2'b10:   ram_count_nxt_s = ram_count_r + CNT_W'(1'b1);
      2'b01:   ram_count_nxt_s = ram_count_r - CNT_W'(1'b1);
      default: ram_count_nxt_s = ram_count_r;
    endcase
  end

  // Total occupancy: only accepted pushes and pops move it.
  always_comb begin
    usage_nxt_s = usage_r;
    case ({push_acc_s, pop_acc_s})
      2'b10:   usage_nxt_s = usage_r + CNT_W'(1'b1);
      2'b01:   usage_nxt_s = usage_r - CNT_W'(1'b1);
      default: usage_nxt_s = usage_r;
    endcase
  end

  // RAM write port; contents are left unreset so the array maps onto SRAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= dtype'(bus.data_i);
    end
  end

  // Pointers, counters, output register and sticky flags; flush beats push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r    <= {ADDR_DEPTH{1'b0}};
      rd_ptr_r    <= {ADDR_DEPTH{1'b0}};
      ram_count_r <= {CNT_W{1'b0}};
      usage_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      data_r      <= dtype'({DATA_WIDTH{1'b0}});
    end else if (bus.flush_i) begin
      // data_r deliberately holds its value across a flush.
      wr_ptr_r    <= {ADDR_DEPTH{1'b0}};
      rd_ptr_r    <= {ADDR_DEPTH{1'b0}};
      ram_count_r <= {CNT_W{1'b0}};
      usage_r     <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      ram_count_r <= ram_count_nxt_s;
      usage_r     <= usage_nxt_s;
      if (push_acc_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_DEPTH'(1'b1);
      end
      if (bus.push_i && full_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.pop_i && !out_valid_r) begin
        underflow_r <= 1'b1;
      end
      if (rd_en_s) begin
        rd_ptr_r    <= rd_ptr_r + ADDR_DEPTH'(1'b1);
        data_r      <= mem_r[rd_ptr_r];
        out_valid_r <= 1'b1;
      end else if (pop_acc_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.data_o         = data_r;
  assign bus.empty_o        = ~out_valid_r;
  assign bus.full_o         = full_s;
  assign bus.usage_o        = usage_r;
  assign bus.almost_full_o  = (32'(usage_r) >= AF_LEVEL);
  assign bus.almost_empty_o = (32'(usage_r) <= AE_LEVEL);
  assign bus.overflow_o     = overflow_r;
  assign bus.underflow_o    = underflow_r;

endmodule
